mips_reg_write_arbiter: RTL and testbench
=========================================

# mips_reg_write_arbiter

Sequencer and arbiter for the `mips_registers` write port. After reset it clears registers 1–31 to zero, one per cycle. It then shares the single write port between two writeback requesters, A (ALU result) and B (secondary/multi-cycle unit), using valid/ready handshakes and round-robin priority. It drives `write_reg`, `write_data` and `signal_reg_write` of the register file directly from registered outputs.

## Interface
- `CLEAR_ON_RESET`, default 1: 1 runs the clear sequence after reset; 0 goes straight to RUN.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `a_valid` in 1: requester A has a write pending.
- `a_reg` in 5: destination register index for A.
- `a_data` in 32: write data for A.
- `a_ready` out 1: combinational; A's request is accepted this cycle.
- `b_valid`, `b_reg`, `b_data`, `b_ready`: same meaning and widths as A, for requester B.
- `write_reg` out 5: registered; to register file `write_reg`.
- `write_data` out 32: registered; to register file `write_data`.
- `signal_reg_write` out 1: registered; to register file `signal_reg_write`.
- `init_done` out 1: registered; high once in RUN.
- `conflict_count` out 8: registered; counts cycles in RUN with `a_valid` and `b_valid` both high; saturates at 255.

## Operation
- **Reset values** (asynchronous, immediate):
  - `write_reg`=0, `write_data`=0, `signal_reg_write`=0
  - `init_done`=0, `conflict_count`=0
  - `a_ready`=`b_ready`=0
  - state=CLEAR (RUN if `CLEAR_ON_RESET`=0), clear index=1
  - last-grant=B, so A wins the first tie.
- **States:** CLEAR and RUN only.
- **CLEAR:**
  - Each edge loads outputs with `write_reg`=clear index, `write_data`=0, `signal_reg_write`=1, then increments the index.
  - The edge that loads index 31 also moves to RUN and sets `init_done`=1.
  - `a_ready` and `b_ready` are held at 0; requests are ignored, not queued.
- **RUN grant:**
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the one not in last-grant. Last-grant updates only on a transfer.
- **Ready and transfer:**
  - `x_ready` = RUN and grant=x. At most one ready is high per cycle.
  - A transfer is `x_valid && x_ready`.
  - On a transfer edge, outputs load `write_reg`=`x_reg`, `write_data`=`x_data`, and `signal_reg_write`=1 if `x_reg`≠0.
  - A request to register 0 is accepted (ready high) with `signal_reg_write`=0, so the write is discarded without a stall.
- **No transfer:** `signal_reg_write` loads 0; `write_reg` and `write_data` hold their previous values.
- **Same destination:** A and B targeting the same register are serialized; the later grant's data is the final value. No merging or forwarding.
- **Requester rules:** the requester must hold valid, reg and data stable until ready. The loser of a tie waits at least one cycle.
- **Reset mid-operation:**
  - In-flight output writes are dropped (`signal_reg_write` forced 0 at once).
  - The clear restarts at register 1.
  - `conflict_count` clears.

## Timing
- Clear sequence: 31 consecutive cycles of `signal_reg_write`=1 after the first edge with `rst` low; `write_reg` runs 1, 2, …, 31.
- `init_done` rises on the same edge that loads register 31. `a_ready`/`b_ready` can be high from the following cycle.
- Handshake-to-output latency is 1 cycle: transfer at edge n, outputs valid after edge n.
- The register file commits at edge n+1, so a value written is readable 2 edges after the transfer edge.
- Throughput: one write per cycle. With both requesters continuously valid, grants strictly alternate A, B, A, B.
- `conflict_count` increments on each RUN edge where both valids are high, independent of grant. It stays at 255 once reached.

## Test plan
- **Clear sequence:** assert `rst`, release, hold both valids high → 31 cycles with `write_reg`=1..31, `write_data`=0 and readies 0; then `init_done`=1, and the register file holds all zeros (reg0 never written).
- **A alone:** A alone valid with `a_reg`=5, `a_data`=0xDEADBEEF → `a_ready`=1 the same cycle; next cycle `write_reg`=5, `write_data`=0xDEADBEEF, `signal_reg_write`=1; register 5 reads 0xDEADBEEF afterwards.
- **Contention:** both valid for 4 cycles with distinct registers (A→3, B→4, each with new data per grant) → grant order A, B, A, B; `conflict_count`=4; no cycle with both readies high.
- **Register 0 write:** `b_reg`=0, `b_data`=0x1234 → `b_ready`=1 and the next cycle has `signal_reg_write`=0; register 0 still reads 0.
- **Same register:** A writes reg 7=0x11 and B writes reg 7=0x22 in the same cycle → A granted first, then B; register 7 ends at 0x22.
- **Reset mid-clear:** assert `rst` asynchronously during the clear at index 12 → `signal_reg_write` drops to 0 immediately; after release the clear restarts at `write_reg`=1 and runs the full 31 cycles.

Source files
------------

// File: rtl/mips_reg_write_arbiter_if.sv
// rtl/mips_reg_write_arbiter_if.sv - requester A/B valid/ready writeback bundle
interface mips_reg_write_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        b_ready;

  // Requester side drives the requests and observes the readies.
  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/mips_reg_write_arbiter.sv
// rtl/mips_reg_write_arbiter.sv - clear-on-reset sequencer and round-robin write-port arbiter
module mips_reg_write_arbiter #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  mips_reg_write_arbiter_if.slave   req,
  output logic [4:0]                write_reg,
  output logic [31:0]               write_data,
  output logic                      signal_reg_write,
  output logic                      init_done,
  output logic [7:0]                conflict_count
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  state_t      state_q, state_d;
  logic [4:0]  clr_idx_q, clr_idx_d;
  logic        last_b_q, last_b_d;       // 1: B held the most recent grant
  logic [4:0]  write_reg_q, write_reg_d;
  logic [31:0] write_data_q, write_data_d;
  logic        we_q, we_d;
  logic        init_done_q, init_done_d;
  logic [7:0]  conflict_q, conflict_d;

  logic run;
  logic grant_a;
  logic grant_b;

  // Grant: a lone requester wins; on a tie the one not granted last time wins.
  // Reset is folded in so the readies are low while rst is asserted.
  always_comb begin
    run     = (state_q == RUN) && !rst;
    grant_a = run && req.a_valid && (!req.b_valid || last_b_q);
    grant_b = run && req.b_valid && (!req.a_valid || !last_b_q);
  end

  assign req.a_ready = grant_a;
  assign req.b_ready = grant_b;

  // Next-state: clear walk in CLEAR, transfer capture and conflict counting in RUN.
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    last_b_d     = last_b_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    we_d         = 1'b0;
    init_done_d  = init_done_q;
    conflict_d   = conflict_q;
    unique case (state_q)
      CLEAR: begin
        write_reg_d  = clr_idx_q;
        write_data_d = 32'd0;
        we_d         = 1'b1;
        clr_idx_d    = clr_idx_q + 5'd1;
        if (clr_idx_q == 5'd31) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        init_done_d = 1'b1;
        if (req.a_valid && req.b_valid && conflict_q != 8'd255) begin
          conflict_d = conflict_q + 8'd1;
        end
        // Register 0 is accepted but never written, so it cannot stall a requester.
        if (grant_a) begin
          write_reg_d  = req.a_reg;
          write_data_d = req.a_data;
          we_d         = (req.a_reg != 5'd0);
          last_b_d     = 1'b0;
        end else if (grant_b) begin
          write_reg_d  = req.b_reg;
          write_data_d = req.b_data;
          we_d         = (req.b_reg != 5'd0);
          last_b_d     = 1'b1;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RESET_STATE;
      clr_idx_q    <= 5'd1;
      last_b_q     <= 1'b1;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
      we_q         <= 1'b0;
      init_done_q  <= 1'b0;
      conflict_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      last_b_q     <= last_b_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      we_q         <= we_d;
      init_done_q  <= init_done_d;
      conflict_q   <= conflict_d;
    end
  end

  assign write_reg        = write_reg_q;
  assign write_data       = write_data_q;
  assign signal_reg_write = we_q;
  assign init_done        = init_done_q;
  assign conflict_count   = conflict_q;

endmodule

// File: tb/tb_mips_reg_write_arbiter.sv
// tb/tb_mips_reg_write_arbiter.sv - directed vector bench for mips_reg_write_arbiter
module tb_mips_reg_write_arbiter;

  logic        clk;
  logic        rst;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        signal_reg_write;
  logic        init_done;
  logic [7:0]  conflict_count;

  mips_reg_write_arbiter_if bus();

  mips_reg_write_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (bus),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .signal_reg_write (signal_reg_write),
    .init_done        (init_done),
    .conflict_count   (conflict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: reg0 hardwired to zero, others seeded with a marker.
  logic [31:0] rf [32];
  bit          rf_seeded = 1'b0;
  int          zero_writes = 0;
  always @(posedge clk) begin
    if (!rf_seeded) begin
      for (int k = 0; k < 32; k++) rf[k] <= (k == 0) ? 32'd0 : 32'hA5A5_A5A5;
      rf_seeded <= 1'b1;
    end else if (signal_reg_write) begin
      if (write_reg == 5'd0) zero_writes <= zero_writes + 1;
      else rf[write_reg] <= write_data;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic set_req(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd);
    bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
    bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects rst to have just been released after an edge; both valids held high.
  task automatic check_clear();
    for (int i = 1; i <= 31; i++) begin
      step();
      chk($sformatf("clr_reg[%0d]", i), 32'(write_reg), i);
      chk($sformatf("clr_data[%0d]", i), write_data, 32'd0);
      chk($sformatf("clr_we[%0d]", i), 32'(signal_reg_write), 32'd1);
      chk($sformatf("clr_done[%0d]", i), 32'(init_done), (i == 31) ? 32'd1 : 32'd0);
      if (i < 31) begin
        chk($sformatf("clr_rdy[%0d]", i), {30'd0, bus.a_ready, bus.b_ready}, 32'd0);
      end
    end
  endtask

  typedef struct {
    logic        av; logic [4:0] ar; logic [31:0] ad;
    logic        bv; logic [4:0] br; logic [31:0] bd;
    logic        e_ar; logic e_br;
    logic        e_we; logic [4:0] e_reg; logic [31:0] e_data; logic [7:0] e_cc;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int both_rdy;

    vecs[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 32'h0,    1, 0, 1, 5, 32'hDEADBEEF, 0};
    vecs[1] = '{0, 0, 32'h0,        1, 0, 32'h1234, 0, 1, 0, 0, 32'h1234,     0};
    vecs[2] = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 0, 32'h1234,     0};
    vecs[3] = '{1, 3, 32'hA1,       1, 4, 32'hB1,   1, 0, 1, 3, 32'hA1,       1};
    vecs[4] = '{1, 3, 32'hA2,       1, 4, 32'hB1,   0, 1, 1, 4, 32'hB1,       2};
    vecs[5] = '{1, 3, 32'hA2,       1, 4, 32'hB2,   1, 0, 1, 3, 32'hA2,       3};
    vecs[6] = '{1, 3, 32'hA3,       1, 4, 32'hB2,   0, 1, 1, 4, 32'hB2,       4};
    vecs[7] = '{1, 7, 32'h11,       1, 7, 32'h22,   1, 0, 1, 7, 32'h11,       5};
    vecs[8] = '{0, 0, 32'h0,        1, 7, 32'h22,   0, 1, 1, 7, 32'h22,       5};
    vecs[9] = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 7, 32'h22,       5};

    rst = 1'b1;
    set_req(1, 9, 32'h5555, 1, 10, 32'h6666);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reg", 32'(write_reg), 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_we", 32'(signal_reg_write), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_cc", 32'(conflict_count), 32'd0);
    chk("rst_rdy", {30'd0, bus.a_ready, bus.b_ready}, 32'd0);
    rst = 1'b0;

    check_clear();
    set_req(0, 0, 0, 0, 0, 0);
    step();
    chk("post_clr_we", 32'(signal_reg_write), 32'd0);
    chk("post_clr_hold", 32'(write_reg), 32'd31);
    chk("post_clr_cc", 32'(conflict_count), 32'd0);
    for (int r = 0; r < 32; r++) chk($sformatf("rf_zero[%0d]", r), rf[r], 32'd0);

    for (int v = 0; v < 10; v++) begin
      set_req(vecs[v].av, vecs[v].ar, vecs[v].ad, vecs[v].bv, vecs[v].br, vecs[v].bd);
      #1;
      chk($sformatf("v%0d_a_ready", v), 32'(bus.a_ready), 32'(vecs[v].e_ar));
      chk($sformatf("v%0d_b_ready", v), 32'(bus.b_ready), 32'(vecs[v].e_br));
      step();
      chk($sformatf("v%0d_we", v), 32'(signal_reg_write), 32'(vecs[v].e_we));
      chk($sformatf("v%0d_reg", v), 32'(write_reg), 32'(vecs[v].e_reg));
      chk($sformatf("v%0d_data", v), write_data, vecs[v].e_data);
      chk($sformatf("v%0d_cc", v), 32'(conflict_count), 32'(vecs[v].e_cc));
    end
    chk("rf5", rf[5], 32'hDEADBEEF);
    chk("rf3", rf[3], 32'hA2);
    chk("rf4", rf[4], 32'hB2);
    chk("rf7", rf[7], 32'h22);
    chk("rf0", rf[0], 32'd0);

    // Long contention run: counter reaches 255 exactly after 250 more conflicts.
    both_rdy = 0;
    set_req(1, 10, 32'hAAAA, 1, 11, 32'hBBBB);
    for (int c = 0; c < 260; c++) begin
      #1;
      if (bus.a_ready && bus.b_ready) both_rdy++;
      step();
      if (c == 249) chk("cc_reach_255", 32'(conflict_count), 32'd255);
    end
    chk("cc_saturated", 32'(conflict_count), 32'd255);
    chk("never_both_ready", both_rdy, 32'd0);

    // Reset asserted asynchronously in the middle of a fresh clear.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (12) step();
    chk("mid_clr_idx", 32'(write_reg), 32'd12);
    chk("mid_clr_we", 32'(signal_reg_write), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async_we", 32'(signal_reg_write), 32'd0);
    chk("async_reg", 32'(write_reg), 32'd0);
    chk("async_cc", 32'(conflict_count), 32'd0);
    chk("async_done", 32'(init_done), 32'd0);
    step();
    rst = 1'b0;
    check_clear();
    set_req(0, 0, 0, 0, 0, 0);
    step();
    chk("restart_end_we", 32'(signal_reg_write), 32'd0);
    chk("restart_cc", 32'(conflict_count), 32'd0);
    chk("reg0_never_written", zero_writes, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
